// File: rtl/mdu_issue_ctrl.sv
// Issue/hazard controller for the multiply/divide unit: gates E-stage ops onto the
// MDU control bus, shadows the MDU busy counter, stalls D on HI/LO hazards, flags errors.
module mdu_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        e_valid_i,
  input  logic [3:0]  e_op_i,
  input  logic [3:0]  d_op_i,
  input  logic        mdu_busy_i,
  output logic [3:0]  mdu_ctrl_o,
  output logic        stall_d_o,
  output logic        shadow_busy_o,
  output logic [3:0]  remaining_o,
  output logic        mismatch_o,
  output logic        issue_err_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd12;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  function automatic logic is_long(input logic [3:0] op);
    return ((op >= OP_MULT) && (op <= OP_DIVU)) || ((op >= OP_MADD) && (op <= OP_MSUBU));
  endfunction

  function automatic logic is_mt(input logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_d_md(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MFLO);
  endfunction

  logic [3:0]  cnt_q, cnt_d;
  logic        chk_en_q, chk_en_d;
  logic        mismatch_q, mismatch_d;
  logic        issue_err_q, issue_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        shadow_busy_s;
  logic        e_cand_s;
  logic [3:0]  mdu_ctrl_s;
  logic        issue_long_s;
  logic        stall_d_s;

  assign shadow_busy_s = (cnt_q != 4'd0);

  // Issue gating and D-stage hazard detection.
  always_comb begin
    e_cand_s     = 1'b0;
    mdu_ctrl_s   = OP_NONE;
    issue_long_s = 1'b0;
    stall_d_s    = 1'b0;
    e_cand_s = e_valid_i && !req_i && (is_long(e_op_i) || is_mt(e_op_i));
    if (e_cand_s && !shadow_busy_s) begin
      mdu_ctrl_s = e_op_i;
    end else begin
      mdu_ctrl_s = OP_NONE;
    end
    issue_long_s = is_long(mdu_ctrl_s);
    // A just-issued long op blocks D in the same cycle, before cnt reflects it.
    stall_d_s = is_d_md(d_op_i) && (shadow_busy_s || issue_long_s);
  end

  // Next state for the shadow counter, sticky flags and stall counter.
  always_comb begin
    cnt_d       = cnt_q;
    chk_en_d    = 1'b1;
    mismatch_d  = mismatch_q;
    issue_err_d = issue_err_q;
    stall_cnt_d = stall_cnt_q;

    // req freezes the MDU, so the shadow must freeze with it.
    if (req_i) begin
      cnt_d = cnt_q;
    end else if (issue_long_s) begin
      cnt_d = is_div(mdu_ctrl_s) ? DIV_LOAD : MUL_LOAD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (chk_en_q && (mdu_busy_i != shadow_busy_s)) begin
      mismatch_d = 1'b1;
    end else begin
      mismatch_d = mismatch_q;
    end

    if (e_cand_s && shadow_busy_s) begin
      issue_err_d = 1'b1;
    end else begin
      issue_err_d = issue_err_q;
    end

    if (stall_d_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 4'd0;
      chk_en_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      issue_err_q <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      cnt_q       <= cnt_d;
      chk_en_q    <= chk_en_d;
      mismatch_q  <= mismatch_d;
      issue_err_q <= issue_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mdu_ctrl_o    = mdu_ctrl_s;
  assign stall_d_o     = stall_d_s;
  assign shadow_busy_o = shadow_busy_s;
  assign remaining_o   = cnt_q;
  assign mismatch_o    = mismatch_q;
  assign issue_err_o   = issue_err_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: directed vectors push expectations, a
// negedge monitor pops and compares; a small MDU model drives mdu_busy.
module tb_mdu_issue_ctrl;

  localparam int SK = -1;

  logic        clk;
  logic        reset;
  logic        req;
  logic        e_valid;
  logic [3:0]  e_op;
  logic [3:0]  d_op;
  logic        mdu_busy;
  logic [3:0]  mdu_ctrl;
  logic        stall_d;
  logic        shadow_busy;
  logic [3:0]  remaining;
  logic        mismatch;
  logic        issue_err;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  int bov      = -1;
  logic [3:0] mcnt;

  typedef struct {
    string name;
    int ctrl, stall, rem, mism, ierr, scnt;
  } exp_t;
  exp_t sb[$];

  mdu_issue_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req_i(req), .e_valid_i(e_valid), .e_op_i(e_op),
    .d_op_i(d_op), .mdu_busy_i(mdu_busy), .mdu_ctrl_o(mdu_ctrl), .stall_d_o(stall_d),
    .shadow_busy_o(shadow_busy), .remaining_o(remaining), .mismatch_o(mismatch),
    .issue_err_o(issue_err), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MDU: takes the op on the control bus, busy for 5 or 10 non-req cycles.
  always @(posedge clk) begin
    if (reset) mcnt <= 4'd0;
    else if (req) mcnt <= mcnt;
    else if (mdu_ctrl == 4'd3 || mdu_ctrl == 4'd4) mcnt <= 4'd10;
    else if ((mdu_ctrl >= 4'd1 && mdu_ctrl <= 4'd2) || (mdu_ctrl >= 4'd7 && mdu_ctrl <= 4'd10)) mcnt <= 4'd5;
    else if (mcnt != 4'd0) mcnt <= mcnt - 4'd1;
  end

  assign mdu_busy = (bov >= 0) ? bov[0] : (mcnt != 4'd0);

  task automatic chk(input string tag, input string fld, input int exp, input logic [31:0] act);
    if (exp >= 0) begin
      checks++;
      if (act !== exp[31:0]) begin
        failures++;
        $display("FAIL %s.%s got=%0d exp=%0d at %0t", tag, fld, act, exp, $time);
      end
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "mdu_ctrl", e.ctrl, {28'd0, mdu_ctrl});
      chk(e.name, "stall_d", e.stall, {31'd0, stall_d});
      chk(e.name, "remaining", e.rem, {28'd0, remaining});
      chk(e.name, "shadow_busy", (e.rem < 0) ? SK : ((e.rem != 0) ? 1 : 0), {31'd0, shadow_busy});
      chk(e.name, "mismatch", e.mism, {31'd0, mismatch});
      chk(e.name, "issue_err", e.ierr, {31'd0, issue_err});
      chk(e.name, "stall_cnt", e.scnt, {16'd0, stall_cnt});
    end
  end

  task automatic step(input string name, input bit rst, input bit rq, input bit ev,
                      input int eop, input int dop, input int bov_i,
                      input int xc, input int xs, input int xr, input int xm,
                      input int xi, input int xn);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    req     = rq;
    e_valid = ev;
    e_op    = eop[3:0];
    d_op    = dop[3:0];
    bov     = bov_i;
    e.name = name; e.ctrl = xc; e.stall = xs; e.rem = xr;
    e.mism = xm; e.ierr = xi; e.scnt = xn;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; e_valid = 1'b0; e_op = 4'd0; d_op = 4'd0;
    step("rst0", 1, 0, 0, 0, 0, SK, SK, SK, SK, SK, SK, SK);
    step("rst_state", 1, 0, 0, 0, 0, SK, 0, 0, 0, 0, 0, 0);
    step("por_idle", 0, 0, 0, 0, 0, SK, 0, 0, 0, 0, 0, 0);

    // MULT with MFLO waiting in D
    step("mult_c0", 0, 0, 1, 1, 12, SK, 1, 1, 0, 0, 0, 0);
    for (int r = 5; r >= 1; r--) step("mult_win", 0, 0, 0, 0, 12, SK, 0, 1, r, 0, 0, 6 - r);
    step("mult_done", 0, 0, 0, 0, 12, SK, 0, 0, 0, 0, 0, 6);

    // DIVU with MULT waiting in D, then MULT issues as remaining hits 0
    step("divu_c0", 0, 0, 1, 4, 1, SK, 4, 1, 0, 0, 0, 6);
    for (int r = 10; r >= 1; r--) step("divu_win", 0, 0, 0, 0, 1, SK, 0, 1, r, 0, 0, 17 - r);
    step("b2b_mult", 0, 0, 1, 1, 1, SK, 1, 1, 0, 0, 0, 17);
    for (int r = 5; r >= 1; r--) step("b2b_win", 0, 0, 0, 0, 0, SK, 0, 0, r, 0, 0, 18);
    step("b2b_done", 0, 0, 0, 0, 0, SK, 0, 0, 0, 0, 0, 18);

    // MULT with req high for 3 cycles from C2; MTLO offered during req
    step("req_c0", 0, 0, 1, 1, 0, SK, 1, 0, 0, 0, 0, 18);
    step("req_c1", 0, 0, 0, 0, 0, SK, 0, 0, 5, 0, 0, 18);
    for (int k = 0; k < 3; k++) step("req_hold", 0, 1, 1, 6, 0, SK, 0, 0, 4, 0, 0, 18);
    for (int r = 4; r >= 1; r--) step("req_win", 0, 0, 0, 0, 0, SK, 0, 0, r, 0, 0, 18);
    step("req_done", 0, 0, 0, 0, 0, SK, 0, 0, 0, 0, 0, 18);

    // MTHI then MFHI in D
    step("mthi", 0, 0, 1, 5, 0, SK, 5, 0, 0, 0, 0, 18);
    step("mfhi_d1", 0, 0, 0, 0, 11, SK, 0, 0, 0, 0, 0, 18);
    step("mfhi_d2", 0, 0, 0, 0, 11, SK, 0, 0, 0, 0, 0, 18);

    // Non-forwarded E ops, then MADDU as a multiply-class long op
    step("inval_mult", 0, 0, 0, 1, 0, SK, 0, 0, 0, 0, 0, 18);
    step("e_mfhi", 0, 0, 1, 11, 0, SK, 0, 0, 0, 0, 0, 18);
    step("e_rsvd", 0, 0, 1, 13, 0, SK, 0, 0, 0, 0, 0, 18);
    step("maddu", 0, 0, 1, 8, 0, SK, 8, 0, 0, 0, 0, 18);
    for (int r = 5; r >= 1; r--) step("maddu_win", 0, 0, 0, 0, 0, SK, 0, 0, r, 0, 0, 18);
    step("maddu_done", 0, 0, 0, 0, 0, SK, 0, 0, 0, 0, 0, 18);

    // DIV dropped while busy; forced busy disagreement
    step("err_c0", 0, 0, 1, 1, 0, SK, 1, 0, 0, 0, 0, 18);
    step("err_c1", 0, 0, 0, 0, 0, SK, 0, 0, 5, 0, 0, 18);
    step("err_c2", 0, 0, 0, 0, 0, SK, 0, 0, 4, 0, 0, 18);
    step("drop_div", 0, 0, 1, 3, 0, SK, 0, 0, 3, 0, 0, 18);
    step("force_busy0", 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 18);
    step("mism_set", 0, 0, 0, 0, 0, SK, 0, 0, 1, 1, 1, 18);
    step("sticky1", 0, 0, 0, 0, 0, SK, 0, 0, 0, 1, 1, 18);
    step("sticky2", 0, 0, 0, 0, 0, SK, 0, 0, 0, 1, 1, 18);

    // Continuous DIV stream with MULT in D: stall every cycle, counter saturates
    for (int i = 0; i < 70008; i++) begin
      int r;
      int sc;
      r  = (i % 11 == 0) ? 0 : 11 - (i % 11);
      sc = (18 + i > 65535) ? 65535 : 18 + i;
      step("sat", 0, 0, 1, 3, 1, SK, (r == 0) ? 3 : 0, 1, r, 1, 1, sc);
    end

    // Reset mid-operation at cnt=7 with flags set and counter saturated
    step("rst_mid", 1, 0, 1, 3, 1, SK, 0, 1, 7, 1, 1, 65535);
    step("post_rst1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("post_rst2", 0, 0, 0, 0, 0, SK, 0, 0, 0, 0, 0, 0);
    step("post_rst3", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("post_rst4", 0, 0, 0, 0, 0, SK, 0, 0, 0, 1, 0, 0);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

Issue and hazard controller on the pipeline side of the multiply/divide unit (MDU). It gates E-stage MDU operations onto the MDU control bus. It keeps a cycle-exact shadow of the MDU busy counter and stalls the D stage when a HI/LO-related instruction would collide with an in-flight operation. It also checks the MDU's `Busy` output against the shadow and counts stall cycles.

## Interface
Parameters:
- `MUL_CYCLES`, default 5: busy length of the MULT/MULTU/MADD/MADDU/MSUB/MSUBU operations.
- `DIV_CYCLES`, default 10: busy length of DIV/DIVU.

Op encoding (4-bit, shared with the MDU control bus):
- 0 NONE
- 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
- 5 MTHI, 6 MTLO
- 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU
- 11 MFHI, 12 MFLO
- 13–15 reserved, treated as NONE

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req` in 1: exception/interrupt request; the MDU freezes while it is high.
- `e_valid` in 1: the E-stage instruction is valid (not a bubble or flushed).
- `e_op` in 4: MDU op of the E-stage instruction.
- `d_op` in 4: MDU op of the D-stage instruction.
- `mdu_busy` in 1: `Busy` output of the MDU.
- `mdu_ctrl` out 4: op driven to the MDU control input.
- `stall_d` out 1: stall request for the D stage.
- `shadow_busy` out 1: predicted MDU busy.
- `remaining` out 4: shadow cycles remaining.
- `mismatch` out 1: sticky flag, `mdu_busy` ≠ `shadow_busy` seen.
- `issue_err` out 1: sticky flag, E-stage op dropped because the shadow was busy.
- `stall_cnt` out 16: saturating count of cycles with `stall_d` high.

## Operation
Op classes:
- Long op (`is_long`): ops 1–4 and 7–10.
- Move-to op (`is_mt`): ops 5–6.
- D-stage MDU instruction (`d_md`): ops 1–12.

Issue (combinational):
- `mdu_ctrl = e_op` when all hold: `e_valid`, `!req`, `shadow_busy == 0`, and `e_op` is a long or move-to op.
- Otherwise `mdu_ctrl = NONE`. MFHI, MFLO and reserved codes are never forwarded.
- `issue_long = (mdu_ctrl` is a long op`)`.

Shadow counter `cnt` (4-bit, `remaining = cnt`, `shadow_busy = (cnt != 0)`), updated at each clock edge:
- `reset`: `cnt` ← 0.
- `req` high: `cnt` holds, mirroring the MDU freeze.
- `issue_long`: `cnt` ← `MUL_CYCLES`, or `DIV_CYCLES` for ops 3–4.
- `cnt != 0`: `cnt` ← `cnt − 1`.
- Move-to ops do not load `cnt`.

Stall (combinational):
- `stall_d = d_md && (shadow_busy || issue_long)`.
- This covers mult/div/mt/mf behind an in-flight or just-issued long op.
- `stall_d` is independent of `req`; the pipeline flush logic overrides it.

Error flags:
- `issue_err` sets when `e_valid && !req && (is_long(e_op) || is_mt(e_op)) && shadow_busy`.
- `mismatch` sets on any cycle after the first post-reset cycle in which `mdu_busy != shadow_busy`.
- Both flags are sticky and cleared only by `reset`.

Stall counter:
- `stall_cnt` increments on each edge where `stall_d` is high.
- It saturates at 0xFFFF and never wraps.

## Timing
Reset values:
- `cnt = 0`, `shadow_busy = 0`, `remaining = 0`.
- `mismatch = 0`, `issue_err = 0`, `stall_cnt = 0`.
- `mdu_ctrl` and `stall_d` follow their combinational equations.

Long-op timing:
- A long op presented in cycle C0 is captured by the MDU at the C0 edge.
- `shadow_busy` is high from C1 for exactly `MUL_CYCLES` (or `DIV_CYCLES`) non-req cycles, matching the MDU `Busy` window edge-for-edge.
- `stall_d` for a dependent D instruction covers C0 plus the busy window: 6 cycles for mult, 11 for div.
- With `req` high for k cycles mid-operation, the window extends by exactly k cycles.

Move-to ops:
- Issue takes one cycle and produces no busy window.
- A following MFHI/MFLO in D does not stall.

Back-to-back ops:
- A new long op may issue in the first cycle after `cnt` reaches 0, which is the first cycle the MDU accepts it.

Reset mid-operation:
- All state clears at that edge.
- `mismatch` is not evaluated in the first cycle after reset.

## Test plan
- Issue MULT with `e_valid=1`, `req=0`, `d_op` = MFLO (12) → `mdu_ctrl = 1` in C0; `shadow_busy` high for C1–C5; `stall_d` high for C0–C5 (6 cycles); `stall_cnt = 6`; `mismatch = 0` against a model MDU.
- Issue DIVU with `d_op` = MULT → `remaining` sequence 10,9,…,1,0; `stall_d` high for 11 cycles; a MULT issues in the cycle `remaining` hits 0.
- Issue MULT, then raise `req` for 3 cycles at C2 → `mdu_ctrl = NONE` during `req`; `remaining` holds at 4; busy window lasts 8 cycles; `mismatch = 0`.
- Issue MTHI, then MFHI in D next cycle → `mdu_ctrl = 5` for 1 cycle; `cnt` stays 0; `stall_d` never asserts.
- Force `e_op` = DIV while `cnt = 3` → `mdu_ctrl = NONE`; `issue_err = 1` and stays set. Force `mdu_busy = 0` while `cnt = 2` → `mismatch = 1` and stays set until reset.
- Assert `reset` at `cnt = 7` with flags set and `stall_cnt` at 0xFFFF → next cycle `cnt = 0`, flags 0, `stall_cnt = 0`. Separately, 70000 consecutive stall cycles → `stall_cnt` holds at 0xFFFF.
